// File: rtl/tlb_pkg.sv
// Shared TLB types: entry image layout, operation codes and controller FSM states.
package tlb_pkg;

    localparam int unsigned TLBNUM_DEF = 16;

    localparam logic [2:0] OpSrch = 3'd0;
    localparam logic [2:0] OpRd   = 3'd1;
    localparam logic [2:0] OpWr   = 3'd2;
    localparam logic [2:0] OpFill = 3'd3;
    localparam logic [2:0] OpInv  = 3'd4;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    // 89 bits; e is the MSB, page 0 sits above page 1.
    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } ctrl_state_e;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Pipeline-side request/response handshake of the TLB op controller.
interface tlb_op_ctrl_if
    import tlb_pkg::*;
#(
    parameter int unsigned TLBNUM = TLBNUM_DEF
);
    localparam int unsigned IW = $clog2(TLBNUM);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_asid;
    logic [18:0]   req_vppn;
    logic [IW-1:0] req_index;
    tlb_entry_t    req_entry;

    logic          resp_valid;
    logic          resp_ready;
    logic          resp_found;
    logic [IW-1:0] resp_index;
    tlb_entry_t    resp_entry;

    modport master (
        output req_valid, req_op, req_inv_op, req_asid, req_vppn, req_index, req_entry,
        output resp_ready,
        input  req_ready, resp_valid, resp_found, resp_index, resp_entry
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_asid, req_vppn, req_index, req_entry,
        input  resp_ready,
        output req_ready, resp_valid, resp_found, resp_index, resp_entry
    );

endinterface

// File: rtl/tlb_fill_sel.sv
// Fill index generator: round-robin counter, or a free-running 4-bit LFSR when
// TLB_FILL_LFSR_EN is defined (TLBNUM must then be 16).
module tlb_fill_sel #(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          adv_i,
    output logic [IW-1:0] idx_o
);

`ifdef TLB_FILL_LFSR_EN
    logic [3:0] lfsr_q, lfsr_d;
    logic       unused_adv;

    assign unused_adv = adv_i;
    // x^4 + x^3 + 1, advances every cycle regardless of FILL activity.
    assign lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    assign idx_o      = IW'(lfsr_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 4'b0001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [IW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == IW'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    assign idx_o = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-op controller: IDLE -> EXEC (one cycle on the TLB ports) -> RESP.
// Fill index source selected by TLB_FILL_LFSR_EN (see tlb_fill_sel).
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int unsigned TLBNUM = TLBNUM_DEF,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_op_ctrl_if.slave  pif,
    output logic          busy,
    output logic [18:0]   s1_vppn,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output tlb_entry_t    tlb_w_entry,
    output logic [IW-1:0] tlb_r_index,
    input  tlb_entry_t    tlb_r_entry,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op
);

    ctrl_state_e   state_q, state_d;
    logic          accept;
    logic          fill_adv;
    logic [IW-1:0] fill_idx;

    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic [IW-1:0] index_q;
    tlb_entry_t    entry_q;

    logic          resp_found_q, resp_found_d;
    logic [IW-1:0] resp_index_q, resp_index_d;
    tlb_entry_t    resp_entry_q, resp_entry_d;

    tlb_fill_sel #(
        .TLBNUM(TLBNUM)
    ) u_fill_sel (
        .clk   (clk),
        .resetn(resetn),
        .adv_i (fill_adv),
        .idx_o (fill_idx)
    );

    // req_ready is gated by resetn so every output reads 0 while reset is held.
    assign accept         = pif.req_valid && (state_q == StIdle);
    assign pif.req_ready  = (state_q == StIdle) && resetn;
    assign busy           = (state_q != StIdle);
    assign pif.resp_valid = (state_q == StResp);
    assign pif.resp_found = resp_found_q;
    assign pif.resp_index = resp_index_q;
    assign pif.resp_entry = resp_entry_q;

    always_comb begin
        state_d      = state_q;
        resp_found_d = resp_found_q;
        resp_index_d = resp_index_q;
        resp_entry_d = resp_entry_q;
        fill_adv     = 1'b0;
        s1_vppn      = '0;
        s1_asid      = '0;
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_w_entry  = '0;
        tlb_r_index  = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StExec;
            end
            StExec: begin
                state_d      = StResp;
                resp_found_d = 1'b0;
                resp_index_d = '0;
                resp_entry_d = '0;
                case (op_q)
                    OpSrch: begin
                        s1_vppn      = vppn_q;
                        s1_asid      = asid_q;
                        resp_found_d = s1_found;
                        resp_index_d = s1_found ? s1_index : '0;
                    end
                    OpRd: begin
                        tlb_r_index  = index_q;
                        resp_entry_d = tlb_r_entry;
                        resp_found_d = tlb_r_entry.e;
                        resp_index_d = index_q;
                    end
                    OpWr: begin
                        tlb_we       = 1'b1;
                        tlb_w_index  = index_q;
                        tlb_w_entry  = entry_q;
                        resp_found_d = 1'b1;
                        resp_index_d = index_q;
                    end
                    OpFill: begin
                        tlb_we       = 1'b1;
                        tlb_w_index  = fill_idx;
                        tlb_w_entry  = entry_q;
                        fill_adv     = 1'b1;
                        resp_found_d = 1'b1;
                        resp_index_d = fill_idx;
                    end
                    OpInv: begin
                        invtlb_valid = 1'b1;
                        invtlb_op    = inv_op_q;
                        s1_vppn      = vppn_q;
                        s1_asid      = asid_q;
                        resp_found_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            StResp: begin
                if (pif.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_found_q <= resp_found_d;
            resp_index_q <= resp_index_d;
            resp_entry_q <= resp_entry_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            vppn_q   <= '0;
            index_q  <= '0;
            entry_q  <= '0;
        end else if (accept) begin
            op_q     <= pif.req_op;
            inv_op_q <= pif.req_inv_op;
            asid_q   <= pif.req_asid;
            vppn_q   <= pif.req_vppn;
            index_q  <= pif.req_index;
            entry_q  <= pif.req_entry;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl (default round-robin fill build) with a small TLB array model.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       busy;
    logic [18:0] s1_vppn;
    logic [9:0] s1_asid;
    logic       s1_found = 1'b0;
    logic [3:0] s1_index = '0;
    logic       tlb_we;
    logic [3:0] tlb_w_index;
    tlb_entry_t tlb_w_entry;
    logic [3:0] tlb_r_index;
    tlb_entry_t tlb_r_entry;
    logic       invtlb_valid;
    logic [4:0] invtlb_op;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int inv_cnt = 0;
    logic [3:0]  last_w_idx = '0;
    logic [4:0]  last_inv_op = '0;
    logic [9:0]  last_inv_asid = '0;
    logic [18:0] last_inv_vppn = '0;

    tlb_entry_t mem [16] = '{default: '0};

    tlb_entry_t e1;
    tlb_entry_t e2;
    tlb_entry_t fent;

    tlb_op_ctrl_if #(.TLBNUM(16)) ifc ();

    tlb_op_ctrl #(
        .TLBNUM(16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pif         (ifc.slave),
        .busy        (busy),
        .s1_vppn     (s1_vppn),
        .s1_asid     (s1_asid),
        .s1_found    (s1_found),
        .s1_index    (s1_index),
        .tlb_we      (tlb_we),
        .tlb_w_index (tlb_w_index),
        .tlb_w_entry (tlb_w_entry),
        .tlb_r_index (tlb_r_index),
        .tlb_r_entry (tlb_r_entry),
        .invtlb_valid(invtlb_valid),
        .invtlb_op   (invtlb_op)
    );

    always #5 clk = ~clk;

    assign tlb_r_entry = mem[tlb_r_index];

    always @(posedge clk) begin
        if (tlb_we) begin
            mem[tlb_w_index] <= tlb_w_entry;
            we_cnt           <= we_cnt + 1;
            last_w_idx       <= tlb_w_index;
        end
        if (invtlb_valid) begin
            inv_cnt       <= inv_cnt + 1;
            last_inv_op   <= invtlb_op;
            last_inv_asid <= s1_asid;
            last_inv_vppn <= s1_vppn;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns in the EXEC cycle.
    task automatic send(input logic [2:0] op, input logic [4:0] inv, input logic [9:0] asid,
                        input logic [18:0] vppn, input logic [3:0] idx, input tlb_entry_t ent);
        chk("idle_req_ready", ifc.req_ready, 1);
        ifc.req_valid  = 1'b1;
        ifc.req_op     = op;
        ifc.req_inv_op = inv;
        ifc.req_asid   = asid;
        ifc.req_vppn   = vppn;
        ifc.req_index  = idx;
        ifc.req_entry  = ent;
        tick();
        ifc.req_valid  = 1'b0;
        ifc.req_op     = '0;
        ifc.req_entry  = '0;
        chk("exec_busy", busy, 1);
        chk("exec_no_resp", ifc.resp_valid, 0);
    endtask

    task automatic to_resp();
        tick();
        chk("resp_valid_t2", ifc.resp_valid, 1);
        chk("resp_req_ready", ifc.req_ready, 0);
    endtask

    task automatic ack();
        ifc.resp_ready = 1'b1;
        tick();
        ifc.resp_ready = 1'b0;
        chk("ack_idle_busy", busy, 0);
        chk("ack_resp_valid", ifc.resp_valid, 0);
    endtask

    initial begin
        int w0;
        e1   = tlb_entry_t'(89'h1_2345_6789_abcd_ef01_2345_67);
        e2   = tlb_entry_t'(89'h1_0000_0000_0000_0000_0000_aa);
        fent = tlb_entry_t'(89'h0_dead_beef_cafe_f00d_1234_56);
        ifc.req_valid  = 1'b0;
        ifc.req_op     = '0;
        ifc.req_inv_op = '0;
        ifc.req_asid   = '0;
        ifc.req_vppn   = '0;
        ifc.req_index  = '0;
        ifc.req_entry  = '0;
        ifc.resp_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_req_ready", ifc.req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", ifc.resp_valid, 0);
        chk("rst_we", tlb_we, 0);
        chk("rst_inv", invtlb_valid, 0);
        chk("rst_resp_entry", ifc.resp_entry, 0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", ifc.req_ready, 1);

        // SRCH hit
        s1_found = 1'b1;
        s1_index = 4'd5;
        send(OpSrch, 5'd0, 10'h011, 19'h00abc, 4'd0, '0);
        chk("srch_s1_vppn", s1_vppn, 19'h00abc);
        chk("srch_s1_asid", s1_asid, 10'h011);
        chk("srch_no_we", tlb_we, 0);
        to_resp();
        chk("srch_found", ifc.resp_found, 1);
        chk("srch_index", ifc.resp_index, 4'd5);
        chk("srch_entry", ifc.resp_entry, 0);
        chk("srch_s1_zero_resp", s1_vppn, 0);
        ack();

        // SRCH miss
        s1_found = 1'b0;
        s1_index = 4'd7;
        send(OpSrch, 5'd0, 10'h022, 19'h7ffff, 4'd0, '0);
        to_resp();
        chk("miss_found", ifc.resp_found, 0);
        chk("miss_index", ifc.resp_index, 0);
        ack();

        // WR index 3 then RD index 3
        w0 = we_cnt;
        send(OpWr, 5'd0, 10'h0, 19'h0, 4'd3, e1);
        chk("wr_we", tlb_we, 1);
        chk("wr_w_index", tlb_w_index, 4'd3);
        chk("wr_w_entry", tlb_w_entry, e1);
        to_resp();
        chk("wr_we_off", tlb_we, 0);
        chk("wr_we_pulses", we_cnt - w0, 1);
        chk("wr_last_idx", last_w_idx, 4'd3);
        chk("wr_found", ifc.resp_found, 1);
        chk("wr_entry", ifc.resp_entry, 0);
        ack();
        send(OpRd, 5'd0, 10'h0, 19'h0, 4'd3, '0);
        chk("rd_r_index", tlb_r_index, 4'd3);
        chk("rd_no_we", tlb_we, 0);
        to_resp();
        chk("rd_entry", ifc.resp_entry, e1);
        chk("rd_found", ifc.resp_found, 1);
        chk("rd_index", ifc.resp_index, 4'd3);
        chk("rd_total_we", we_cnt - w0, 1);
        ack();

        // INV
        send(OpInv, 5'd5, 10'h02a, 19'h01234, 4'd0, '0);
        chk("inv_valid", invtlb_valid, 1);
        chk("inv_op", invtlb_op, 5'd5);
        chk("inv_asid", s1_asid, 10'h02a);
        chk("inv_vppn", s1_vppn, 19'h01234);
        chk("inv_no_we", tlb_we, 0);
        to_resp();
        chk("inv_valid_off", invtlb_valid, 0);
        chk("inv_pulses", inv_cnt, 1);
        chk("inv_mon_op", last_inv_op, 5'd5);
        chk("inv_mon_asid", last_inv_asid, 10'h02a);
        chk("inv_mon_vppn", last_inv_vppn, 19'h01234);
        chk("inv_found", ifc.resp_found, 1);
        chk("inv_entry", ifc.resp_entry, 0);
        ack();

        // Reserved op: no side effect, zeroed response
        s1_found = 1'b1;
        s1_index = 4'd9;
        w0 = we_cnt;
        send(3'd6, 5'd3, 10'h3ff, 19'h55555, 4'd2, e1);
        chk("rsv_no_we", tlb_we, 0);
        chk("rsv_no_inv", invtlb_valid, 0);
        chk("rsv_s1_vppn", s1_vppn, 0);
        to_resp();
        chk("rsv_found", ifc.resp_found, 0);
        chk("rsv_index", ifc.resp_index, 0);
        chk("rsv_entry", ifc.resp_entry, 0);
        chk("rsv_we_cnt", we_cnt - w0, 0);
        chk("rsv_inv_cnt", inv_cnt, 1);
        ack();

        // Round-robin fill: 16 fills walk 0..15, the 17th wraps to 0
        for (int i = 0; i < 16; i++) begin
            send(OpFill, 5'd0, 10'h0, 19'h0, 4'd0, fent);
            chk("fill_we", tlb_we, 1);
            chk("fill_w_index", tlb_w_index, i[3:0]);
            to_resp();
            chk("fill_resp_index", ifc.resp_index, i[3:0]);
            ack();
        end
        send(OpFill, 5'd0, 10'h0, 19'h0, 4'd0, fent);
        chk("fill_wrap_index", tlb_w_index, 4'd0);
        to_resp();
        chk("fill_wrap_resp", ifc.resp_index, 4'd0);
        chk("fill_entry_zero", ifc.resp_entry, 0);
        ack();

        // Backpressure: response held stable for 10 cycles
        s1_found = 1'b1;
        s1_index = 4'd12;
        send(OpSrch, 5'd0, 10'h001, 19'h00001, 4'd0, '0);
        to_resp();
        s1_found = 1'b0;
        s1_index = 4'd0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_valid", ifc.resp_valid, 1);
            chk("bp_found", ifc.resp_found, 1);
            chk("bp_index", ifc.resp_index, 4'd12);
            chk("bp_req_ready", ifc.req_ready, 0);
            chk("bp_busy", busy, 1);
            tick();
        end
        ack();

        // Reset asserted during EXEC of a WR
        w0 = we_cnt;
        send(OpWr, 5'd0, 10'h0, 19'h0, 4'd9, e2);
        chk("rstx_we_before", tlb_we, 1);
        resetn = 1'b0;
        #1;
        chk("rstx_we_cut", tlb_we, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_resp_valid", ifc.resp_valid, 0);
        tick();
        chk("rstx_we_cnt", we_cnt - w0, 0);
        chk("rstx_mem9", mem[9], fent);
        resetn = 1'b1;
        #1;
        chk("rstx_ready_after", ifc.req_ready, 1);
        send(OpFill, 5'd0, 10'h0, 19'h0, 4'd0, fent);
        chk("rstx_fill_seed", tlb_w_index, 4'd0);
        to_resp();
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter: TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM) is the index width.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, all state on posedge
  resetn  in  1  asynchronous active-low reset
  req_valid / req_ready  in / out  1 / 1  op request handshake from pipeline
  req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 reserved
  req_inv_op  in  5  INVTLB op code
  req_asid / req_vppn  in  10 / 19  search/invalidate key
  req_index  in  IW  RD/WR target index
  req_entry  in  89  entry image for WR/FILL (tlb_entry_t)
  resp_valid / resp_ready  out / in  1 / 1  result handshake to CSR unit
  resp_found / resp_index / resp_entry  out  1 / IW / 89  result fields
  busy  out  1  controller owns TLB s1 port and write port
  s1_vppn / s1_asid  out  19 / 10  drive to TLB search port 1
  s1_found / s1_index  in  1 / IW  TLB search result
  tlb_we / tlb_w_index / tlb_w_entry  out  1 / IW / 89  TLB write port
  tlb_r_index / tlb_r_entry  out / in  IW / 89  TLB read port
  invtlb_valid / invtlb_op  out  1 / 5  TLB invalidate control

Function
REQ-003 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-004 SHALL register req_* on req_valid&&req_ready and enter EXEC next cycle.
REQ-005 EXEC SHALL last exactly one cycle; TLB side outputs driven from registered request only in EXEC, zero otherwise.
REQ-006 SRCH: s1_vppn/s1_asid driven in EXEC; end of EXEC capture resp_found=s1_found, resp_index=s1_found?s1_index:0.
REQ-007 RD: tlb_r_index=req_index in EXEC; capture resp_entry=tlb_r_entry, resp_found=entry E bit, resp_index=req_index.
REQ-008 WR: tlb_we=1 for exactly one cycle in EXEC, tlb_w_index=req_index, tlb_w_entry=req_entry; resp_found=1.
REQ-009 FILL: as WR but tlb_w_index = fill index sampled in EXEC; resp_index returns that index.
REQ-010 INV: invtlb_valid=1 one cycle in EXEC, invtlb_op=req_inv_op, s1_asid/s1_vppn driven from request; resp_found=1.
REQ-011 Reserved req_op SHALL cause no TLB side effect; response with resp_found=0, resp_index=0, resp_entry=0.
REQ-012 RESP SHALL hold resp_valid=1 and stable fields until resp_ready; transfer returns to IDLE; new request earliest the cycle after.
REQ-013 Latency: accept edge T, EXEC cycle T+1, resp_valid first high cycle T+2.
REQ-014 resp_entry SHALL be 0 for SRCH/WR/FILL/INV.

Reset
REQ-015 resetn low SHALL asynchronously force IDLE, all outputs 0 (req_ready 1 after release), request/response regs 0, fill counter to reset seed.
REQ-016 Reset during EXEC SHALL suppress tlb_we/invtlb_valid immediately; no partial write.

Configuration
REQ-017 Macro TLB_FILL_LFSR_EN defined: fill index = 4-bit Fibonacci LFSR x^4+x^3+1, seed 4'b0001, advancing every clock; TLBNUM SHALL be 16.
REQ-018 Macro undefined: fill index = round-robin counter, reset 0, increments after each FILL, wraps TLBNUM-1 -> 0.

Structure
REQ-019 Shared package tlb_pkg SHALL hold tlb_entry_t (89b: e, vppn19, ps6, asid10, g, {ppn20,plv2,mat2,d,v}x2 for page 0 then 1), op codes, TLBNUM default.
REQ-020 Fill index generator SHALL be sub-module tlb_fill_sel; the rest is flat.

Verification
REQ-021 SRCH hit: TLB returns s1_found=1, s1_index=5 -> resp at T+2 with found=1, index=5, entry=0.
REQ-022 WR index 3 then RD index 3 -> exactly one tlb_we pulse, w_index=3; RD resp_entry equals written image, found=E.
REQ-023 Round-robin: four FILLs from reset -> w_index 0,1,2,3; after 16 FILLs next is 0.
REQ-024 INV op 5, asid 0x2A, vppn 0x1234 -> one invtlb_valid cycle with op=5, s1_asid=0x2A, s1_vppn=0x1234.
REQ-025 resp_ready held low 10 cycles -> resp fields stable, req_ready 0, busy 1 throughout.
REQ-026 resetn asserted in EXEC of WR -> tlb_we 0 same cycle, FSM IDLE, no entry changed.
